piso_shift_tx: RTL and testbench
================================

// Module: piso_shift_tx
//
// PURPOSE
//   Parametrised parallel-in / serial-out transmitter with a valid/ready input handshake.
//   Has a one-word holding buffer, so consecutive words are serialised with no idle gaps.
//   Bit order (MSB- or LSB-first) is selectable per word.
//   Sits between the RAM read path and the SPI MISO driver; replaces the fixed 8-bit shifter.
//   Drives an explicit ser_valid flag instead of a high-impedance idle state.
//
// PARAMETERS
//   WIDTH   8   data word width in bits; legal range WIDTH >= 2
//   CNT_W   $clog2(WIDTH+1)   bit-counter width; derived, do not override
//
// PORTS
//   clk        in   1      system clock; all state updates on rising edge
//   rst        in   1      synchronous reset, active-high
//   in_data    in   WIDTH  parallel word to transmit
//   in_lsb     in   1      bit order for this word: 1 = LSB first, 0 = MSB first
//   in_valid   in   1      in_data/in_lsb are valid
//   in_ready   out  1      block can accept a word; transfer when in_valid && in_ready at rising edge
//   ser_out    out  1      serial data bit (registered)
//   ser_valid  out  1      ser_out carries a frame bit this cycle
//   ser_last   out  1      current bit is the final bit of the frame
//   busy       out  1      shifter holds an active frame (== ser_valid)
//
// BEHAVIOUR
//   Reset (rst=1 at a rising edge):
//     - ser_out, ser_valid, ser_last, busy = 0.
//     - Buffer emptied; bit counter = 0.
//     - in_ready = 0 while rst is high.
//     - Reset mid-frame aborts the frame and discards any buffered word; nothing is resumed.
//   in_ready = !buf_full && !rst (combinational).
//   States:
//     - IDLE: shifter empty.
//     - SHIFT: presenting data bits.
//     - PAR: presenting the parity bit; only with P2S_PARITY_EN.
//   Frame length: FL = WIDTH (WIDTH+1 with parity).
//   IDLE, buffer empty, accept at edge N:
//     - Word loads straight into the shifter; in_lsb is captured with it.
//     - ser_out = first bit, ser_valid = 1 after edge N (latency 1 cycle).
//   SHIFT: each edge presents the next bit:
//     - MSB-first order: in_data[WIDTH-1] .. in_data[0].
//     - LSB-first order: in_data[0] .. in_data[WIDTH-1].
//   Bit k (0-based) of the frame is presented after edge N+k; ser_last = 1 only on bit FL-1.
//   Accept while SHIFT/PAR: word (with its in_lsb) goes to the buffer; buf_full = 1, in_ready = 0.
//   End of frame (edge after bit FL-1 presented):
//     - Buffer full: buffer moves to the shifter and its first bit is presented at that edge.
//       Gapless, ser_valid stays 1. buf_full clears and in_ready rises the following cycle.
//     - Buffer empty: go to IDLE; ser_valid = ser_last = busy = 0, ser_out = 0.
//   Accept on the same edge as end of frame with buffer empty:
//     - Word loads straight into the shifter; still gapless.
//   in_data, in_lsb are ignored when no transfer occurs.
//   in_valid may drop without a transfer.
//   Counter increments once per presented bit and resets to 0 on each load. No wrap beyond FL-1.
//
// CONFIGURATION
//   `define P2S_PARITY_EN defined:
//     - After the last data bit, a PAR state presents the even-parity bit (^word).
//     - FL = WIDTH+1; ser_last is asserted on the parity bit.
//   P2S_PARITY_EN undefined:
//     - No PAR state; FL = WIDTH; ser_last is asserted on the last data bit.
//
// TESTING
//   1. WIDTH=8, in_data=8'h0F, in_lsb=0, single accept
//      -> ser_out 0,0,0,0,1,1,1,1 on cycles 1..8; ser_last on cycle 8; ser_valid=0 on cycle 9.
//   2. Same word, in_lsb=1
//      -> ser_out 1,1,1,1,0,0,0,0; busy high for exactly 8 cycles.
//   3. Words 8'h0F (MSB-first) then 8'hF0 (LSB-first), in_valid held high
//      -> 16 contiguous ser_valid cycles: 0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1.
//      -> in_ready low while the buffer is full; two ser_last pulses (cycles 8, 16).
//   4. Reset after the 3rd bit, with a word buffered
//      -> edge after rst: ser_valid=0, ser_last=0.
//      -> in_ready=1 once rst=0; the buffered word is never transmitted.
//   5. P2S_PARITY_EN, in_data=8'h07 MSB-first
//      -> 0,0,0,0,0,1,1,1 then parity 1 on cycle 9 with ser_last.
//      -> Without the macro: 8 bits, ser_last on cycle 8.
//   6. WIDTH=5, in_data=5'h13, in_lsb=0
//      -> ser_out 1,0,0,1,1; ser_last on cycle 5.

Source files
------------

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter, valid/ready input, one-word buffer.
// Optional even-parity bit when P2S_PARITY_EN is defined.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_data, in_lsb    word and its bit order (1 = LSB first)
//   in_valid, in_ready input handshake; transfer on valid && ready
//   ser_out            registered serial bit
//   ser_valid          ser_out carries a frame bit
//   ser_last           final bit of the frame
//   busy               frame in progress (same as ser_valid)
module piso_shift_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_lsb,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

`ifdef P2S_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic             sh_lsb;
  logic [WIDTH-1:0] buf_data;
  logic             buf_lsb;
  logic             buf_full;
  logic [CNT_W-1:0] cnt;
`ifdef P2S_PARITY_EN
  logic             par_bit;
`endif

  logic             accept;
  logic             last_data;
  logic             frame_end;
  logic             do_load;
  logic             buf_wr;
  logic [WIDTH-1:0] ld_data;
  logic             ld_lsb;

  assign in_ready  = !buf_full && !rst;
  assign accept    = in_valid && in_ready;
  assign busy      = ser_valid;
  assign last_data = (cnt == CNT_W'(WIDTH - 1));

`ifdef P2S_PARITY_EN
  assign frame_end = (state == PAR);
`else
  assign frame_end = (state == SHIFT) && last_data;
`endif

  // A pending buffered word always wins; it is only
  // ever non-empty while a frame is running.
  assign ld_data = buf_full ? buf_data : in_data;
  assign ld_lsb  = buf_full ? buf_lsb  : in_lsb;

  assign do_load = ((state == IDLE) && accept) ||
                   (frame_end && (buf_full || accept));

  assign buf_wr  = accept && (state != IDLE) && !frame_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sh        <= '0;
      sh_lsb    <= 1'b0;
      buf_data  <= '0;
      buf_lsb   <= 1'b0;
      buf_full  <= 1'b0;
      cnt       <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
`ifdef P2S_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      if (buf_wr) begin
        buf_data <= in_data;
        buf_lsb  <= in_lsb;
        buf_full <= 1'b1;
      end else if (do_load && buf_full) begin
        buf_full <= 1'b0;
      end

      if (do_load) begin
        // First bit goes out on the load edge; the
        // shifter keeps the remaining bits.
        state     <= SHIFT;
        cnt       <= '0;
        ser_valid <= 1'b1;
        ser_last  <= 1'b0;
        sh_lsb    <= ld_lsb;
        if (ld_lsb) begin
          ser_out <= ld_data[0];
          sh      <= ld_data >> 1;
        end else begin
          ser_out <= ld_data[WIDTH-1];
          sh      <= ld_data << 1;
        end
`ifdef P2S_PARITY_EN
        par_bit   <= ^ld_data;
`endif
      end else if (frame_end) begin
        state     <= IDLE;
        cnt       <= '0;
        ser_out   <= 1'b0;
        ser_valid <= 1'b0;
        ser_last  <= 1'b0;
      end else if (state == SHIFT) begin
`ifdef P2S_PARITY_EN
        if (last_data) begin
          state    <= PAR;
          ser_out  <= par_bit;
          ser_last <= 1'b1;
          cnt      <= cnt + CNT_W'(1);
        end else
`endif
        begin
          cnt      <= cnt + CNT_W'(1);
          ser_last <= (cnt == CNT_W'(FL - 2));
          if (sh_lsb) begin
            ser_out <= sh[0];
            sh      <= sh >> 1;
          end else begin
            ser_out <= sh[WIDTH-1];
            sh      <= sh << 1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Randomised scoreboard bench for piso_shift_tx.
// Reference model predicts the cycle of every frame bit.
module tb_piso_shift_tx;

  localparam int WIDTH = 8;
`ifdef P2S_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_lsb = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             busy;

  piso_shift_tx #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_lsb    (in_lsb),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_last  (ser_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit b;
    bit last;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   next_free = 0;
  int   last_start = -1;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  // Model: a word accepted at edge N starts at
  // max(N, end of previous frame) and occupies FL edges.
  always @(posedge clk) begin
    int   s;
    exp_t e;
    cyc++;
    if (rst) begin
      q.delete();
      next_free  = cyc;
      last_start = -1;
    end else if (in_valid && in_ready) begin
      s = (cyc > next_free) ? cyc : next_free;
      for (int k = 0; k < WIDTH; k++) begin
        e.cyc  = s + k;
        e.b    = in_lsb ? in_data[k] : in_data[WIDTH-1-k];
        e.last = (k == FL - 1);
        q.push_back(e);
      end
      if (FL > WIDTH) begin
        e.cyc  = s + WIDTH;
        e.b    = ^in_data;
        e.last = 1'b1;
        q.push_back(e);
      end
      next_free  = s + FL;
      last_start = s;
    end
  end

  always @(negedge clk) begin
    bit ev;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      chk("missed_bit_cycle", cyc, q[0].cyc);
      void'(q.pop_front());
    end
    ev = (q.size() > 0) && (q[0].cyc == cyc);
    chk("ser_valid", ser_valid, ev);
    chk("busy", busy, ev);
    if (ev) begin
      chk("ser_out", ser_out, q[0].b);
      chk("ser_last", ser_last, q[0].last);
      void'(q.pop_front());
    end else begin
      chk("idle_out_last", {ser_out, ser_last}, 2'b00);
    end
    chk("in_ready", in_ready, !rst && !(last_start > cyc));
  end

  task automatic send(input logic [WIDTH-1:0] d,
                      input logic l);
    bit ok = 1'b0;
    in_data  = d;
    in_lsb   = l;
    in_valid = 1'b1;
    for (int t = 0; t < 4 * FL; t++) begin
      @(posedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    #2 in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("ready_after_reset", in_ready, 1);

    send(8'h0F, 1'b0);
    chk("t1_latency_valid", ser_valid, 1);
    chk("t1_first_bit", ser_out, 0);
    idle(FL + 3);

    send(8'h0F, 1'b1);
    chk("t2_first_bit", ser_out, 1);
    idle(FL + 3);

    send(8'h0F, 1'b0);
    send(8'hF0, 1'b1);
    chk("t3_ready_buffer_full", in_ready, 0);
    idle(2 * FL + 3);

    send(8'hA5, 1'b0);
    send(8'h3C, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_valid_after_rst", ser_valid, 0);
    chk("t4_last_after_rst", ser_last, 0);
    #1 rst = 1'b0;
    #1 chk("t4_ready_after_rst", in_ready, 1);
    idle(2 * FL + 3);

    send(8'h07, 1'b0);
    idle(FL + 3);

    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #2;
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = WIDTH'($urandom);
      in_lsb   = 1'($urandom);
      rst      = ($urandom_range(0, 149) == 0);
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst      = 1'b0;
    idle(3 * FL);
    chk("drain_queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
